// File: rtl/uart_rx_oversample.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_oversample
// Description : 8N1 UART receiver with an oversampling tick generator. A
//               2-of-3 majority vote is taken around each bit centre. It has a
//               single-entry output register with a valid/ready handshake.
//               Frame-error and overrun events are reported as one-cycle
//               pulses.
// Ports       : clk                - system clock, rising edge
//               rst_n              - synchronous active-low reset
//               soft_reset_request - one-cycle pulse, aborts reception
//               uart_rx            - asynchronous serial input, idles high
//               baud_divisor       - clk cycles per bit, 0 = parameter default
//               rx_ready           - consumer accepts rx_data
//               rx_data/rx_valid   - received byte and its valid flag
//               rx_busy            - a frame is being received
//               frame_error        - pulse: stop bit sampled low
//               overrun            - pulse: completed byte dropped
//               uart_rts_n         - request to send (active low) = rx_valid
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_oversample #(
    parameter int CLK_FREQ_HZ = 125_000_000,
    parameter int BAUD_RATE   = 115200,
    parameter int OVERSAMPLE  = 16          // even, >= 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        soft_reset_request,
    input  logic        uart_rx,
    input  logic [15:0] baud_divisor,
    input  logic        rx_ready,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_busy,
    output logic        frame_error,
    output logic        overrun,
    output logic        uart_rts_n
);

    localparam int RAW_DIV     = CLK_FREQ_HZ / BAUD_RATE;
    localparam int DEF_DIV_INT = (RAW_DIV < 1) ? 1 : ((RAW_DIV > 65535) ? 65535 : RAW_DIV);
    localparam logic [15:0] DEF_DIV = 16'(DEF_DIV_INT);

    localparam int SCW = $clog2(OVERSAMPLE);
    localparam logic [SCW-1:0] SMP_LAST = SCW'(OVERSAMPLE - 1);
    localparam logic [SCW-1:0] SMP_PRE  = SCW'(OVERSAMPLE / 2 - 1);
    localparam logic [SCW-1:0] SMP_MID  = SCW'(OVERSAMPLE / 2);
    localparam logic [SCW-1:0] SMP_POST = SCW'(OVERSAMPLE / 2 + 1);
    localparam logic [SCW-1:0] SMP_ONE  = SCW'(1);
    localparam logic [15:0]    OVS_W    = 16'(OVERSAMPLE);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_HIGH = 3'd4
    } state_t;

    state_t         state;
    logic           sync_0;
    logic           rx_s;
    logic [15:0]    active_div;
    logic [15:0]    tick_cnt;
    logic [SCW-1:0] sample_cnt;
    logic [2:0]     bit_cnt;
    logic [7:0]     shift;
    logic           vote_a;
    logic           vote_b;

    logic [15:0]    config_div;
    logic [15:0]    div_q;
    logic [15:0]    tick_limit;
    logic           sample_tick;
    logic           decide;
    logic           vote;

    assign config_div  = (baud_divisor != 16'd0) ? baud_divisor : DEF_DIV;
    assign div_q       = active_div / OVS_W;
    assign tick_limit  = (div_q == 16'd0) ? 16'd0 : div_q - 16'd1;
    assign sample_tick = (state != S_IDLE) && (tick_cnt == tick_limit);
    // The third vote sample arrives live on rx_s; the first two were captured earlier.
    assign decide      = sample_tick && (sample_cnt == SMP_POST);
    assign vote        = (vote_a & vote_b) | (vote_a & rx_s) | (vote_b & rx_s);

    assign rx_busy     = (state != S_IDLE);
    assign uart_rts_n  = rx_valid;

    always_ff @(posedge clk) begin
        if (!rst_n || soft_reset_request) begin
            sync_0      <= 1'b1;
            rx_s        <= 1'b1;
            state       <= S_IDLE;
            tick_cnt    <= 16'd0;
            sample_cnt  <= '0;
            bit_cnt     <= 3'd0;
            shift       <= 8'h00;
            vote_a      <= 1'b0;
            vote_b      <= 1'b0;
            rx_data     <= 8'h00;
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
            // A soft reset picks up the current configuration immediately.
            active_div  <= (!rst_n) ? DEF_DIV : config_div;
        end else begin
            sync_0      <= uart_rx;
            rx_s        <= sync_0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;

            // Consumption; a delivery in the same cycle overrides this below.
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            if (state == S_IDLE) begin
                tick_cnt   <= 16'd0;
                sample_cnt <= '0;
            end else begin
                if (sample_tick) begin
                    tick_cnt   <= 16'd0;
                    sample_cnt <= (sample_cnt == SMP_LAST) ? '0 : sample_cnt + SMP_ONE;
                end else begin
                    tick_cnt   <= tick_cnt + 16'd1;
                end
                if (sample_tick && (sample_cnt == SMP_PRE)) vote_a <= rx_s;
                if (sample_tick && (sample_cnt == SMP_MID)) vote_b <= rx_s;
            end

            case (state)
                S_IDLE: begin
                    // Divisor tracks the configuration only between frames.
                    active_div <= config_div;
                    bit_cnt    <= 3'd0;
                    if (!rx_s) state <= S_START;
                end
                S_START: begin
                    // A start bit that votes high was a glitch: drop silently.
                    if (decide) state <= vote ? S_IDLE : S_DATA;
                end
                S_DATA: begin
                    if (decide) begin
                        shift   <= {vote, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (decide) begin
                        state <= vote ? S_IDLE : S_WAIT_HIGH;
                        if (!vote) begin
                            frame_error <= 1'b1;
                        end else if (rx_valid && !rx_ready) begin
                            overrun <= 1'b1;
                        end else begin
                            rx_data  <= shift;
                            rx_valid <= 1'b1;
                        end
                    end
                end
                S_WAIT_HIGH: begin
                    // Hold off through a line break until the line recovers.
                    if (rx_s) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
